fft8_frame_sequencer: RTL and testbench
=======================================

FFT8_FRAME_SEQUENCER -- requirements
Module: fft8_frame_sequencer

Interface
REQ-001 Parameter W, default 8, sample width in bits.
REQ-002 Parameter DP_LAT, default 0, datapath latency in cycles; legal range 0..7.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 s_valid  input  1  upstream sample valid.
REQ-006 s_data  input  W  upstream sample.
REQ-007 s_ready  output  1  sequencer can accept a sample.
REQ-008 dp_in  output  8*W  frame to the 8-lane datapath; lane i = dp_in[W*i +: W].
REQ-009 dp_start  output  1  one-cycle launch strobe to the datapath.
REQ-010 dp_out  input  8*W  8-lane datapath result, same lane packing.
REQ-011 m_valid  output  1  downstream sample valid.
REQ-012 m_data  output  W  downstream sample.
REQ-013 m_ready  input  1  downstream accepts.
REQ-014 m_last  output  1  high with m_valid on lane-7 beat.
REQ-015 busy  output  1  any frame held in the input buffer, datapath or output buffer.
REQ-016 frames_done  output  8  count of fully drained frames, wraps 255->0.

Function
REQ-017 Input side: in_cnt 0..8; s_ready = (in_cnt < 8); beat accepted when s_valid & s_ready; sample k (0-based arrival order) stored in input lane k.
REQ-018 dp_in driven from input buffer registers; SHALL remain stable from dp_start cycle through capture edge.
REQ-019 Datapath FSM states: DP_IDLE, DP_RUN.
REQ-020 DP_IDLE -> DP_RUN when registered in_cnt == 8 and out_full == 0; dp_start high for exactly the first DP_RUN cycle (cycle C0).
REQ-021 DP_RUN: lat_cnt counts 0..DP_LAT; dp_out captured into output buffer at rising edge ending cycle C0+DP_LAT; same edge sets out_full=1, clears in_cnt to 0, returns to DP_IDLE.
REQ-022 With DP_LAT=0: dp_start in cycle after 8th accepted beat; m_valid in the following cycle (2 cycles after the accepting cycle).
REQ-023 Input buffer refills (s_ready=1) from cycle C0+DP_LAT+1, overlapping output drain.
REQ-024 Output side: rd_idx 0..7; m_valid = out_full; m_data = output lane rd_idx; m_last = out_full & (rd_idx == 7).
REQ-025 On m_valid & m_ready: rd_idx increments; on last beat rd_idx wraps to 0, out_full clears, frames_done increments.
REQ-026 m_data/m_last SHALL hold while m_valid & !m_ready (no drop, no advance).
REQ-027 Launch after drain: earliest dp_start is cycle after the last-beat handshake edge; no combinational ready-to-start path.
REQ-028 Input full while out_full=1: s_ready=0, in_cnt holds at 8, input buffer holds; no overwrite.
REQ-029 s_valid while s_ready=0 SHALL have no effect.
REQ-030 busy = (in_cnt != 0) | DP_RUN | out_full.

Reset
REQ-031 rst_n low asynchronously forces: in_cnt=0, rd_idx=0, out_full=0, DP_IDLE, lat_cnt=0, frames_done=0.
REQ-032 During reset: s_ready=0, dp_start=0, m_valid=0, m_last=0, busy=0; buffer contents need not be cleared; dp_in/m_data don't-care.
REQ-033 Reset mid-frame (fill, DP_RUN or drain) discards the partial frame; first beat after release lands in lane 0.
REQ-034 s_ready rises in first cycle after rst_n deasserts synchronously to clk.

Verification
REQ-035 DP_LAT=0, bench datapath model dp_out lane i = dp_in lane 7-i, send 1..8, m_ready=1 -> dp_start 1 cycle after 8th beat, m_data 8,7,...,1 on 8 consecutive cycles, m_last on value 1, frames_done=1.
REQ-036 DP_LAT=3, same model, send 1..8 -> dp_start exactly one cycle, capture 3 cycles later, m_valid in cycle C0+4, dp_in stable throughout.
REQ-037 m_ready=0 held after frame A (1..8), send frame B (9..16) -> s_ready=0 after 16th beat, no second dp_start; release m_ready -> A drains 8..1, then B launches, drains 16..9.
REQ-038 m_ready toggled 1,0,1,0 during drain -> each value held while stalled, no duplicate or skipped sample.
REQ-039 Assert rst_n low after 5 beats, release, send 1..8 -> output 8..1 (partial frame discarded), frames_done=1.
REQ-040 256 back-to-back frames -> frames_done wraps to 0; no throughput bubble in s_ready beyond DP_LAT+1 cycles per frame while m_ready=1.

Source files
------------

// File: rtl/fft8_frame_sequencer.sv
// fft8_frame_sequencer
// Collects eight serial samples into a frame and launches it into an external
// 8-lane datapath. The datapath result is captured into an output buffer and
// streamed out one lane per beat. Refilling the input frame overlaps with
// draining the previous result.
module fft8_frame_sequencer #(
   parameter int W      = 8,
   parameter int DP_LAT = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             s_valid,
   input  logic [W-1:0]     s_data,
   output logic             s_ready,
   output logic [8*W-1:0]   dp_in,
   output logic             dp_start,
   input  logic [8*W-1:0]   dp_out,
   output logic             m_valid,
   output logic [W-1:0]     m_data,
   input  logic             m_ready,
   output logic             m_last,
   output logic             busy,
   output logic [7:0]       frames_done
);

   // Last lat_cnt value of a run; the result is captured at the edge ending it.
   localparam logic [2:0] LAT_LAST = 3'(DP_LAT);

   typedef enum logic {
      DP_IDLE,
      DP_RUN
   } dp_state_t;

   dp_state_t      r_state;
   dp_state_t      w_state_next;

   logic           r_in_en;
   logic [3:0]     r_in_cnt;
   logic [W-1:0]   r_in_buf  [8];
   logic [W-1:0]   r_out_buf [8];
   logic           r_out_full;
   logic [2:0]     r_rd_idx;
   logic [2:0]     r_lat_cnt;
   logic [2:0]     w_lat_cnt_next;
   logic [7:0]     r_frames_done;

   logic           w_accept;
   logic           w_capture;
   logic           w_drain;
   logic           w_last_beat;
   logic [3:0]     w_in_cnt_next;
   logic           w_out_full_next;

   // s_ready is held low until the first clock edge after reset release.
   assign s_ready         = r_in_en & ~r_in_cnt[3];
   assign w_accept        = s_valid & s_ready;
   assign w_capture       = (r_state == DP_RUN) && (r_lat_cnt == LAT_LAST);
   assign w_drain         = r_out_full & m_ready;
   assign w_last_beat     = w_drain & (r_rd_idx == 3'd7);
   assign w_in_cnt_next   = w_capture ? 4'd0 :
                            (w_accept ? r_in_cnt + 4'd1 : r_in_cnt);
   assign w_out_full_next = w_capture | (r_out_full & ~w_last_beat);

   assign m_valid     = r_out_full;
   assign m_data      = r_out_buf[r_rd_idx];
   assign m_last      = r_out_full & (r_rd_idx == 3'd7);
   assign busy        = (r_in_cnt != 4'd0) | (r_state == DP_RUN) | r_out_full;
   assign frames_done = r_frames_done;

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_lane
         assign dp_in[W*gi +: W] = r_in_buf[gi];

         // Input lane gi takes the sample that arrives as beat gi of the frame.
         always_ff @(posedge clk) begin
            if (w_accept && (r_in_cnt[2:0] == 3'(gi))) begin
               r_in_buf[gi] <= s_data;
            end
         end

         // Output lane gi is loaded from the datapath at the capture edge.
         always_ff @(posedge clk) begin
            if (w_capture) begin
               r_out_buf[gi] <= dp_out[W*gi +: W];
            end
         end
      end
   endgenerate

   // Input-side enable and fill counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_in_en  <= 1'b0;
         r_in_cnt <= 4'd0;
      end else begin
         r_in_en  <= 1'b1;
         r_in_cnt <= w_in_cnt_next;
      end
   end

   // Output-side occupancy, read pointer and completed-frame counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_full    <= 1'b0;
         r_rd_idx      <= 3'd0;
         r_frames_done <= 8'd0;
      end else begin
         r_out_full <= w_out_full_next;
         if (w_drain) begin
            r_rd_idx <= r_rd_idx + 3'd1;
         end
         if (w_last_beat) begin
            r_frames_done <= r_frames_done + 8'd1;
         end
      end
   end

   // Datapath FSM state and latency counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= DP_IDLE;
         r_lat_cnt <= 3'd0;
      end else begin
         r_state   <= w_state_next;
         r_lat_cnt <= w_lat_cnt_next;
      end
   end

   // Launch as soon as the next-cycle view shows a full input frame and a free
   // output buffer; dp_start is therefore a function of registered state only.
   always_comb begin
      w_state_next   = r_state;
      w_lat_cnt_next = r_lat_cnt;
      dp_start       = 1'b0;
      case (r_state)
         DP_IDLE: begin
            w_lat_cnt_next = 3'd0;
            if ((w_in_cnt_next == 4'd8) && !w_out_full_next) begin
               w_state_next = DP_RUN;
            end
         end
         DP_RUN: begin
            dp_start = (r_lat_cnt == 3'd0);
            if (w_capture) begin
               w_state_next   = DP_IDLE;
               w_lat_cnt_next = 3'd0;
            end else begin
               w_lat_cnt_next = r_lat_cnt + 3'd1;
            end
         end
         default: begin
            w_state_next   = DP_IDLE;
            w_lat_cnt_next = 3'd0;
         end
      endcase
   end

endmodule

// File: tb/tb_fft8_frame_sequencer.sv
// Bench for fft8_frame_sequencer: one instance with zero datapath latency and
// one with a three-cycle datapath; both datapath models reverse the lanes.
module tb_fft8_frame_sequencer;

   localparam int W = 8;

   typedef struct packed {
      logic [W-1:0] d;
      logic         l;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // lat-0 instance signals
   logic             s_valid0 = 1'b0;
   logic [W-1:0]     s_data0  = '0;
   logic             s_ready0;
   logic [8*W-1:0]   dp_in0;
   logic             dp_start0;
   logic [8*W-1:0]   dp_out0;
   logic             m_valid0;
   logic [W-1:0]     m_data0;
   logic             m_ready0 = 1'b1;
   logic             m_last0;
   logic             busy0;
   logic [7:0]       fd0;

   // lat-3 instance signals
   logic             s_valid3 = 1'b0;
   logic [W-1:0]     s_data3  = '0;
   logic             s_ready3;
   logic [8*W-1:0]   dp_in3;
   logic             dp_start3;
   logic [8*W-1:0]   dp_out3;
   logic             m_valid3;
   logic [W-1:0]     m_data3;
   logic             m_ready3 = 1'b1;
   logic             m_last3;
   logic             busy3;
   logic [7:0]       fd3;

   int   n_checks = 0;
   int   n_fail   = 0;

   exp_t sb0_q[$];
   exp_t sb3_q[$];

   int   n_start0 = 0, start_cyc0 = -1, first_v0 = -1, last_cyc0 = -1, last_acc0 = -1;
   int   n_start3 = 0, c0_3 = -1, first_v3 = -1, last_acc3 = -1;
   logic [8*W-1:0] snap3 = '0;
   logic [2:0]     dl3;

   function automatic logic [8*W-1:0] rev8(input logic [8*W-1:0] x);
      logic [8*W-1:0] r;
      for (int i = 0; i < 8; i++) r[W*i +: W] = x[W*(7-i) +: W];
      return r;
   endfunction

   // Datapath models: the result is only valid when the latency has elapsed.
   assign dp_out0 = dp_start0 ? rev8(dp_in0) : {(8*W){1'b1}};
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) dl3 <= 3'd0;
      else        dl3 <= {dl3[1:0], dp_start3};
   end
   assign dp_out3 = dl3[2] ? rev8(dp_in3) : {(8*W){1'b1}};

   fft8_frame_sequencer #(.W(W), .DP_LAT(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .s_valid(s_valid0), .s_data(s_data0), .s_ready(s_ready0),
      .dp_in(dp_in0), .dp_start(dp_start0), .dp_out(dp_out0),
      .m_valid(m_valid0), .m_data(m_data0), .m_ready(m_ready0), .m_last(m_last0),
      .busy(busy0), .frames_done(fd0)
   );

   fft8_frame_sequencer #(.W(W), .DP_LAT(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n),
      .s_valid(s_valid3), .s_data(s_data3), .s_ready(s_ready3),
      .dp_in(dp_in3), .dp_start(dp_start3), .dp_out(dp_out3),
      .m_valid(m_valid3), .m_data(m_data3), .m_ready(m_ready3), .m_last(m_last3),
      .busy(busy3), .frames_done(fd3)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // Monitor for the lat-0 instance: compares every valid cycle against the
   // scoreboard head, so a stalled beat must hold its value.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (dp_start0) begin
               n_start0++;
               start_cyc0 = cyc;
            end
            if (m_valid0) begin
               if (first_v0 < 0) first_v0 = cyc;
               check("sb0_has_entry", 64'(sb0_q.size() > 0), 64'd1);
               if (sb0_q.size() > 0) begin
                  e = sb0_q[0];
                  check("m_data0", 64'(m_data0), 64'(e.d));
                  check("m_last0", 64'(m_last0), 64'(e.l));
                  if (m_ready0) begin
                     void'(sb0_q.pop_front());
                     if (e.l) last_cyc0 = cyc;
                  end
               end
            end
         end
      end
   end

   // Monitor for the lat-3 instance: launch timing, dp_in stability, refill.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (dp_start3) begin
               n_start3++;
               c0_3  = cyc;
               snap3 = dp_in3;
            end else if (c0_3 >= 0 && cyc <= c0_3 + 3) begin
               check("dp_in_stable3", 64'(dp_in3), 64'(snap3));
            end
            if (c0_3 >= 0 && cyc == c0_3 + 3) check("s_ready_hold3", 64'(s_ready3), 64'd0);
            if (c0_3 >= 0 && cyc == c0_3 + 4) check("s_ready_refill3", 64'(s_ready3), 64'd1);
            if (m_valid3) begin
               if (first_v3 < 0) first_v3 = cyc;
               check("sb3_has_entry", 64'(sb3_q.size() > 0), 64'd1);
               if (sb3_q.size() > 0) begin
                  e = sb3_q[0];
                  check("m_data3", 64'(m_data3), 64'(e.d));
                  check("m_last3", 64'(m_last3), 64'(e.l));
                  if (m_ready3) void'(sb3_q.pop_front());
               end
            end
         end
      end
   end

   task automatic send_beat(input bit sel, input logic [W-1:0] d);
      int t;
      bit done;
      t    = 0;
      done = 1'b0;
      if (sel) begin s_valid3 = 1'b1; s_data3 = d; end
      else     begin s_valid0 = 1'b1; s_data0 = d; end
      while (!done && t < 1000) begin
         @(negedge clk);
         done = sel ? s_ready3 : s_ready0;
         if (done) begin
            if (sel) last_acc3 = cyc;
            else     last_acc0 = cyc;
         end
         @(posedge clk);
         #1;
         t++;
      end
      check("beat_accepted", 64'(done), 64'd1);
      if (sel) s_valid3 = 1'b0;
      else     s_valid0 = 1'b0;
   endtask

   task automatic send_frame(input bit sel, input int base);
      exp_t e;
      for (int k = 0; k < 8; k++) send_beat(sel, W'(base + k));
      for (int k = 7; k >= 0; k--) begin
         e.d = W'(base + k);
         e.l = (k == 0);
         if (sel) sb3_q.push_back(e);
         else     sb0_q.push_back(e);
      end
   endtask

   task automatic wait_drain0();
      int t;
      t = 0;
      while ((sb0_q.size() != 0 || m_valid0) && t < 3000) begin
         @(posedge clk);
         #1;
         t++;
      end
      check("drain_empty0", 64'(sb0_q.size()), 64'd0);
   endtask

   task automatic clr_stats0();
      n_start0   = 0;
      start_cyc0 = -1;
      first_v0   = -1;
      last_cyc0  = -1;
   endtask

   task automatic apply_reset();
      @(posedge clk);
      #1;
      rst_n    = 1'b0;
      s_valid0 = 1'b0;
      s_valid3 = 1'b0;
      #1;
      check("rst_s_ready0", 64'(s_ready0), 64'd0);
      check("rst_m_valid0", 64'(m_valid0), 64'd0);
      check("rst_m_last0", 64'(m_last0), 64'd0);
      check("rst_busy0", 64'(busy0), 64'd0);
      check("rst_dp_start0", 64'(dp_start0), 64'd0);
      check("rst_fd0", 64'(fd0), 64'd0);
      check("rst_s_ready3", 64'(s_ready3), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      sb0_q.delete();
      sb3_q.delete();
      check("s_ready_pre_edge0", 64'(s_ready0), 64'd0);
      @(posedge clk);
      #1;
      check("s_ready_post_release0", 64'(s_ready0), 64'd1);
      clr_stats0();
   endtask

   // Hard stop in case something never completes.
   initial begin
      #1000000;
      $display("FAIL watchdog expired checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int span;

      apply_reset();

      // Lat-3 instance: single frame, launch/capture timing.
      send_frame(1'b1, 1);
      repeat (20) @(posedge clk);
      #1;
      check("n_start3", 64'(n_start3), 64'd1);
      check("c0_after_accept3", 64'(c0_3), 64'(last_acc3 + 1));
      check("m_valid_at_c0p4_3", 64'(first_v3), 64'(c0_3 + 4));
      check("sb3_empty", 64'(sb3_q.size()), 64'd0);
      check("fd3", 64'(fd3), 64'd1);

      // Single frame at zero latency with m_ready held high.
      clr_stats0();
      send_frame(1'b0, 1);
      wait_drain0();
      check("n_start0_t1", 64'(n_start0), 64'd1);
      check("start_after_accept0", 64'(start_cyc0), 64'(last_acc0 + 1));
      check("m_valid_latency0", 64'(first_v0), 64'(last_acc0 + 2));
      check("drain_span0", 64'(last_cyc0 - first_v0), 64'd7);
      check("fd0_t1", 64'(fd0), 64'd1);
      check("busy0_idle", 64'(busy0), 64'd0);

      // Output back-pressure: second frame fills but must not launch.
      clr_stats0();
      m_ready0 = 1'b0;
      send_frame(1'b0, 1);
      send_frame(1'b0, 9);
      repeat (10) @(negedge clk);
      check("s_ready_full0", 64'(s_ready0), 64'd0);
      check("no_second_start0", 64'(n_start0), 64'd1);
      check("busy0_full", 64'(busy0), 64'd1);
      @(posedge clk);
      #1;
      m_ready0 = 1'b1;
      wait_drain0();
      check("n_start0_t2", 64'(n_start0), 64'd2);
      check("fd0_t2", 64'(fd0), 64'd3);

      // m_ready toggling during fill and drain.
      fork
         send_frame(1'b0, 17);
         begin
            repeat (30) begin
               @(posedge clk);
               #1;
               m_ready0 = ~m_ready0;
            end
         end
      join
      m_ready0 = 1'b1;
      wait_drain0();
      check("fd0_t3", 64'(fd0), 64'd4);

      // Reset after a partial frame; the next frame starts in lane 0.
      for (int k = 0; k < 5; k++) send_beat(1'b0, W'(101 + k));
      apply_reset();
      send_frame(1'b0, 1);
      wait_drain0();
      check("fd0_after_reset", 64'(fd0), 64'd1);

      // 256 back-to-back frames: throughput and counter wrap.
      apply_reset();
      span = cyc;
      for (int f = 0; f < 256; f++) send_frame(1'b0, f * 8);
      span = last_acc0 - span;
      check("throughput_ok", 64'(span <= 256 * 8 + 255 * 1 - 1), 64'd1);
      wait_drain0();
      check("n_start0_t5", 64'(n_start0), 64'd256);
      check("fd0_wrap", 64'(fd0), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
